// File: rtl/ps2_frame_receiver_if.sv
// Consumer-side bus of the PS/2 frame receiver: show-ahead byte stream with
// valid/ready handshake plus the current FIFO occupancy.
interface ps2_frame_receiver_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_W-1:0]           data_out_ram;
  logic                        data_valid;
  logic                        data_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output data_out_ram,
    output data_valid,
    output fifo_count,
    input  data_ready
  );

  modport slave (
    input  data_out_ram,
    input  data_valid,
    input  fifo_count,
    output data_ready
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// Oversampling PS/2 receiver: synchronise and deglitch k_clock/k_data, assemble
// and validate 11-bit frames, buffer good bytes in a show-ahead FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus idle, waiting for the falling edge carrying the start bit
// RECEIVE | shifting in bits on each falling edge, watching the timeout
// CHECK   | one cycle: validate start/stop/parity, push byte or flag error
module ps2_frame_receiver #(
  parameter int DATA_W         = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   k_clock,
  input  logic                   k_data,
  ps2_frame_receiver_if.master   rx,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   timeout_err,
  output logic                   overflow,
  input  logic                   clear_err
);

  localparam int FRAME_W = DATA_W + 3;
  localparam int BCW     = $clog2(FRAME_W + 1);
  localparam int TOW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLW     = $clog2(FILTER_LEN + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // input conditioning
  logic [1:0]     clk_sync;
  logic [1:0]     dat_sync;
  logic [FLW-1:0] clk_fcnt;
  logic [FLW-1:0] dat_fcnt;
  logic           clk_filt;
  logic           dat_filt;
  logic           clk_filt_q;
  logic           fall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], k_clock};
      dat_sync <= {dat_sync[0], k_data};
    end
  end

  // A line flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_sync[1] != clk_filt) begin
      if (clk_fcnt == FLW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
    end else begin
      clk_fcnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dat_filt <= 1'b1;
      dat_fcnt <= '0;
    end else if (dat_sync[1] != dat_filt) begin
      if (dat_fcnt == FLW'(FILTER_LEN - 1)) begin
        dat_filt <= dat_sync[1];
        dat_fcnt <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + 1'b1;
      end
    end else begin
      dat_fcnt <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) clk_filt_q <= 1'b1;
    else        clk_filt_q <= clk_filt;
  end

  assign fall = clk_filt_q & ~clk_filt;

  // frame state machine
  state_t             state, state_nx;
  logic [BCW-1:0]     bit_cnt, bit_cnt_nx;
  logic [FRAME_W-1:0] shreg, shreg_nx;
  logic [TOW-1:0]     to_cnt, to_cnt_nx;
  logic               push;
  logic               perr_nx, ferr_nx, terr_nx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      to_cnt      <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      bit_cnt     <= bit_cnt_nx;
      shreg       <= shreg_nx;
      to_cnt      <= to_cnt_nx;
      parity_err  <= perr_nx;
      frame_err   <= ferr_nx;
      timeout_err <= terr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    to_cnt_nx  = to_cnt;
    push       = 1'b0;
    perr_nx    = 1'b0;
    ferr_nx    = 1'b0;
    terr_nx    = 1'b0;
    case (state)
      IDLE: begin
        to_cnt_nx = '0;
        if (fall) begin
          shreg_nx   = {dat_filt, shreg[FRAME_W-1:1]};
          bit_cnt_nx = BCW'(1);
          state_nx   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (fall) begin
          shreg_nx   = {dat_filt, shreg[FRAME_W-1:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          to_cnt_nx  = '0;
          if (bit_cnt == BCW'(FRAME_W - 1)) state_nx = CHECK;
        end else if (to_cnt == TOW'(TIMEOUT_CYCLES)) begin
          terr_nx    = 1'b1;
          to_cnt_nx  = '0;
          bit_cnt_nx = '0;
          state_nx   = IDLE;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      CHECK: begin
        // Framing errors mask parity: a bad frame's parity bit is meaningless.
        if (shreg[0] || !shreg[FRAME_W-1]) ferr_nx = 1'b1;
        else if (!(^shreg[FRAME_W-2:1]))    perr_nx = 1'b1;
        else                                push    = 1'b1;
        bit_cnt_nx = '0;
        to_cnt_nx  = '0;
        state_nx   = IDLE;
      end
      default: begin
        bit_cnt_nx = '0;
        to_cnt_nx  = '0;
        state_nx   = IDLE;
      end
    endcase
  end

  // show-ahead FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, pop, wr_en, ovf_evt;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rx.data_valid & rx.data_ready;
  assign wr_en   = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the output is gated while empty.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= shreg[DATA_W:1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         overflow <= 1'b0;
    else if (ovf_evt)   overflow <= 1'b1;
    else if (clear_err) overflow <= 1'b0;
  end

  assign rx.data_valid   = (count != '0);
  assign rx.fifo_count   = count;
  assign rx.data_out_ram = rx.data_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomised frame stimulus against a queue-based model of the receiver's
// frame rules, FIFO occupancy and error reporting.
module tb_ps2_frame_receiver;
  localparam int DATA_W         = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 300;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic k_clock = 1'b1;
  logic k_data = 1'b1;
  logic clear_err = 1'b0;
  logic parity_err, frame_err, timeout_err, overflow;

  ps2_frame_receiver_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) rx_if ();

  ps2_frame_receiver #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
    .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .k_clock(k_clock), .k_data(k_data),
    .rx(rx_if), .parity_err(parity_err), .frame_err(frame_err),
    .timeout_err(timeout_err), .overflow(overflow), .clear_err(clear_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int n_par = 0, n_frm = 0, n_to = 0;
  int e_par = 0, e_frm = 0, e_to = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0;

  always @(negedge clock) begin
    if (parity_err)  n_par++;
    if (frame_err)   n_frm++;
    if (timeout_err) n_to++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // kind: 0 good, 1 bad parity, 2 stop=0, 3 start=1
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input int kind);
    logic start, par, stop;
    start = (kind == 3);
    par   = ~(^d) ^ (kind == 1);
    stop  = (kind != 2);
    return {stop, par, d, start};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits, input int hp, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      k_data = fr[i];
      wait_cyc(hp);
      k_clock = 1'b0;
      wait_cyc(hp);
      k_clock = 1'b1;
      if (i == glitch_bit) begin
        wait_cyc(10);
        k_clock = 1'b0;
        wait_cyc(2);
        k_clock = 1'b1;
        wait_cyc(4);
      end
    end
    k_data = 1'b1;
  endtask

  task automatic check_state(input string tag);
    @(negedge clock);
    check({tag, ".par"},   n_par, e_par);
    check({tag, ".frm"},   n_frm, e_frm);
    check({tag, ".to"},    n_to, e_to);
    check({tag, ".count"}, rx_if.fifo_count, q.size());
    check({tag, ".valid"}, rx_if.data_valid, q.size() != 0);
    check({tag, ".ovf"},   overflow, m_ovf);
    if (q.size() != 0) check({tag, ".head"}, rx_if.data_out_ram, q[0]);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input int kind, input int glitch);
    send_bits(mk_frame(d, kind), 11, $urandom_range(12, 30), glitch);
    case (kind)
      0: if (q.size() < FIFO_DEPTH) q.push_back(d); else m_ovf = 1'b1;
      1: e_par++;
      default: e_frm++;
    endcase
    wait_cyc(20);
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 64) begin
      @(negedge clock);
      check({tag, ".dvalid"}, rx_if.data_valid, 1'b1);
      check({tag, ".dbyte"}, rx_if.data_out_ram, q[0]);
      void'(q.pop_front());
      rx_if.data_ready = 1'b1;
      @(negedge clock);
      rx_if.data_ready = 1'b0;
      guard++;
    end
    @(negedge clock);
    check({tag, ".empty_valid"}, rx_if.data_valid, 1'b0);
    check({tag, ".empty_count"}, rx_if.fifo_count, 0);
  endtask

  initial begin
    logic [7:0] rb;
    int rk;
    rx_if.data_ready = 1'b0;
    wait_cyc(5);
    @(negedge clock);
    check("rst.valid", rx_if.data_valid, 1'b0);
    check("rst.count", rx_if.fifo_count, 0);
    check("rst.data",  rx_if.data_out_ram, 0);
    check("rst.errs",  {parity_err, frame_err, timeout_err, overflow}, 0);
    reset = 1'b1;
    wait_cyc(10);

    do_frame("f1c", 8'h1C, 0, -1);
    drain("d1");
    do_frame("par1c", 8'h1C, 1, -1);
    do_frame("fF0", 8'hF0, 0, -1);
    drain("d2");

    do_frame("o1", 8'h1C, 0, -1);
    do_frame("o2", 8'hF0, 0, -1);
    do_frame("o3", 8'h1C, 0, -1);
    do_frame("o4", 8'h32, 0, -1);
    do_frame("o5", 8'h29, 0, -1);
    drain("d3");
    @(negedge clock); clear_err = 1'b1;
    @(negedge clock); clear_err = 1'b0;
    m_ovf = 1'b0;
    check("clr.ovf", overflow, 1'b0);

    send_bits(mk_frame(8'hA5, 0), 5, 20, -1);
    wait_cyc(TIMEOUT_CYCLES + 10);
    e_to++;
    wait_cyc(10);
    check_state("tmo");
    do_frame("after_to", 8'h1C, 0, -1);
    drain("d4");

    do_frame("glitch5a", 8'h5A, 0, 4);
    do_frame("stop0", 8'h5A, 2, -1);
    drain("d5");

    for (int i = 0; i < 24; i++) begin
      rb = 8'($urandom_range(0, 255));
      rk = $urandom_range(0, 6);
      if (rk > 3) rk = 0;
      do_frame("rnd", rb, rk, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
      if ($urandom_range(0, 1) == 1) drain("rnd_d");
    end

    do_frame("pre_rst", 8'hF0, 0, -1);
    send_bits(mk_frame(8'h77, 0), 6, 20, -1);
    @(negedge clock); reset = 1'b0;
    wait_cyc(3);
    @(negedge clock);
    check("mrst.valid", rx_if.data_valid, 1'b0);
    check("mrst.count", rx_if.fifo_count, 0);
    check("mrst.data",  rx_if.data_out_ram, 0);
    check("mrst.errs",  {parity_err, frame_err, timeout_err, overflow}, 0);
    q.delete();
    m_ovf = 1'b0;
    reset = 1'b1;
    wait_cyc(10);
    do_frame("post_rst", 8'h1C, 0, -1);
    drain("d6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Successor to the raw keyboard shift register. Runs entirely in the system clock domain and oversamples the PS/2 k_clock and k_data lines.
- Deglitches both lines and assembles 11-bit frames: start, DATA_W data bits LSB first, odd parity, stop.
- Validates each frame and buffers good bytes in a FIFO with a valid/ready handshake toward the RAM/animator logic.
- Reports parity, framing, timeout and overflow errors.

Parameters:
- DATA_W, 8: data bits per frame.
- FIFO_DEPTH, 4: buffered bytes. Power of 2, ≥2.
- FILTER_LEN, 4: consecutive equal synced samples required before the filtered line changes. ≥1.
- TIMEOUT_CYCLES, 5000: maximum system clocks allowed between falling edges inside a frame (100 us at 50 MHz).

Ports:
- clock, input, 1: system clock. All logic is on its rising edge.
- reset, input, 1: asynchronous, active-low reset.
- k_clock, input, 1: PS/2 clock line. Asynchronous to clock.
- k_data, input, 1: PS/2 data line. Asynchronous to clock.
- data_out_ram, output, DATA_W: FIFO head byte. Valid only while data_valid=1.
- data_valid, output, 1: FIFO not empty.
- data_ready, input, 1: consumer accepts the head byte when data_valid & data_ready.
- fifo_count, output, clog2(FIFO_DEPTH)+1: number of bytes held.
- parity_err, output, 1: one-cycle pulse.
- frame_err, output, 1: one-cycle pulse. Bad start or stop bit.
- timeout_err, output, 1: one-cycle pulse.
- overflow, output, 1: sticky. Cleared by reset or clear_err.
- clear_err, input, 1: synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; bit counter, timeout counter and FIFO pointers go to 0.
  - data_out_ram=0, data_valid=0, fifo_count=0, all error outputs 0.
  - Synchronisers and filtered lines reset to 1 (bus idle).
  - Reset asserted mid-frame discards the partial frame; no error is reported.
- Input conditioning:
  - Each line passes through a 2-flop synchroniser, then the filter.
  - A filtered line takes a new value only after FILTER_LEN consecutive synced samples differ from its current value.
  - fall = filtered k_clock changed 1→0 this cycle.
  - The data bit is the filtered k_data value on the cycle fall=1.
- State machine:
  - IDLE: on fall, capture the start bit, set bit count to 1 and go to RECEIVE.
  - RECEIVE: on each fall, shift the bit in and increment the count. On the 11th bit go to CHECK.
  - CHECK (one cycle): evaluate the frame, then return to IDLE.
    - start≠0 or stop≠1: frame_err pulse, no push. This takes priority over parity.
    - Otherwise, XOR of data bits and parity bit = 0: parity_err pulse, no push.
    - Otherwise: push the data byte.
  - Timeout counter clears on every fall and counts while in RECEIVE. When it reaches TIMEOUT_CYCLES: timeout_err pulse, discard the frame, go to IDLE.
- Latency: data_valid rises the cycle after CHECK, i.e. 2 cycles after the 11th fall.
- FIFO:
  - Show-ahead: data_out_ram presents the head byte whenever non-empty. A pop advances it on the next edge.
  - Push while full with no pop in the same cycle: byte dropped, overflow←1.
  - Push and pop in the same cycle when full: both occur; count unchanged; no overflow.
  - Push and pop in the same cycle when empty: push only (data_valid is 0, so no pop).
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous clear_err and a new overflow event: overflow=1 (set wins).
- k_data is never driven; the block is receive-only.

Test Plan:
- Send 0x1C as bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1, with a 40 us bit period → data_valid=1 and data_out_ram=0x1C 2 cycles after the last fall; no error pulses.
- Send 0x1C with parity 1 → one parity_err pulse, data_valid stays 0. Then send 0xF0 (parity 1) → 0xF0 delivered.
- With data_ready=0, send 0x1C, 0xF0, 0x1C, 0x32, 0x29 → fifo_count=4, overflow=1. Drain with data_ready=1 → 0x1C, 0xF0, 0x1C, 0x32 in order, data_valid=0 afterwards. Pulse clear_err → overflow=0.
- Send 5 bits, then hold k_clock high for TIMEOUT_CYCLES+10 → one timeout_err pulse. A following complete frame 0x1C is received correctly.
- With FILTER_LEN=4, inject a 2-cycle low glitch on k_clock mid-frame → ignored; frame 0x5A is received intact. Stop bit driven 0 → frame_err, no push.
- Assert reset for 3 cycles after 6 bits of a frame → all outputs 0 / IDLE. The next full frame 0x1C is received with no errors.
